// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// base opcodes, datapath select codes and instruction classes. The
// immediate generator and the ALU decoder import the same definitions.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4 = 2'd0,
    PC_SRC_ALU   = 2'd1,
    PC_SRC_JALR  = 2'd2
  } pc_src_e;

  localparam logic ALU_A_RS1    = 1'b0;
  localparam logic ALU_A_OLD_PC = 1'b1;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'd0,
    ALU_OP_BRANCH = 2'd1,
    ALU_OP_FUNCT  = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_I_ALU  = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } inst_cls_e;

  // States in which the memory handshake is live.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational opcode decoder: legality, immediate format and
// instruction class. Shared by the DECODE, EXEC, MEM and WB decoding.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       legal_o,
  output logic [2:0] imm_sel_o,
  output logic [3:0] cls_o
);

  // Map each RV32I base opcode to its class and immediate format.
  always_comb begin
    legal_o   = 1'b1;
    imm_sel_o = IMM_I;
    cls_o     = CLS_NONE;
    case (opcode_i)
      OPC_OP: begin
        imm_sel_o = IMM_I;  // no immediate; I keeps the generator quiet
        cls_o     = CLS_R;
      end
      OPC_OP_IMM: begin
        imm_sel_o = IMM_I;
        cls_o     = CLS_I_ALU;
      end
      OPC_LOAD: begin
        imm_sel_o = IMM_I;
        cls_o     = CLS_LOAD;
      end
      OPC_STORE: begin
        imm_sel_o = IMM_S;
        cls_o     = CLS_STORE;
      end
      OPC_BRANCH: begin
        imm_sel_o = IMM_B;
        cls_o     = CLS_BRANCH;
      end
      OPC_JAL: begin
        imm_sel_o = IMM_J;
        cls_o     = CLS_JAL;
      end
      OPC_JALR: begin
        imm_sel_o = IMM_I;
        cls_o     = CLS_JALR;
      end
      OPC_LUI: begin
        imm_sel_o = IMM_U;
        cls_o     = CLS_LUI;
      end
      OPC_AUIPC: begin
        imm_sel_o = IMM_U;
        cls_o     = CLS_AUIPC;
      end
      default: begin
        legal_o   = 1'b0;
        imm_sel_o = IMM_I;
        cls_o     = CLS_NONE;
      end
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Sequences
// FETCH/DECODE/EXEC/MEM/WB, decodes every datapath select from the
// current state and opcode, watches memory wait time and counts
// retired instructions.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic [2:0]       imm_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_iord,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal_inst,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_dbg
);

  // The wait counter only has to reach MAX_WAIT; it never runs past it
  // because hitting the limit leaves for TRAP.
  localparam int unsigned       WAIT_W     = (MAX_WAIT < 32'd2) ? 32'd1 : $clog2(MAX_WAIT + 32'd1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic              WAIT_EN    = (MAX_WAIT != 32'd0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic              legal_s;
  logic [2:0]        imm_sel_s;
  logic [3:0]        cls_raw_s;
  inst_cls_e         cls_s;
  logic [WAIT_W-1:0] wait_inc_s;
  logic              timeout_s;
  logic              retire_s;

  rv_ctrl_decode u_decode (
    .opcode_i  (opcode),
    .legal_o   (legal_s),
    .imm_sel_o (imm_sel_s),
    .cls_o     (cls_raw_s)
  );

  assign cls_s      = inst_cls_e'(cls_raw_s);
  assign wait_inc_s = wait_q + WAIT_W'(1'b1);
  assign timeout_s  = WAIT_EN && (wait_inc_s == WAIT_LIMIT);

  // State register; reset parks the FSM in IDLE with every output low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the retire strobe for the instruction counter.
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_s) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (legal_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
        end
      end
      ST_EXEC: begin
        case (cls_s)
          CLS_R, CLS_I_ALU, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC: state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            state_d  = ST_FETCH;
            retire_s = 1'b1;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          case (cls_s)
            CLS_LOAD: state_d = ST_WB;
            CLS_STORE: begin
              state_d  = ST_FETCH;
              retire_s = 1'b1;
            end
            default: state_d = ST_TRAP;
          endcase
        end else if (timeout_s) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        state_d  = ST_FETCH;
        retire_s = 1'b1;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // Wait-counter next value: restart on entering a memory state, count
  // each stalled request cycle otherwise.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) && is_mem_state(state_d)) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (mem_req && !mem_ready) begin
      wait_d = wait_inc_s;
    end else begin
      wait_d = wait_q;
    end
  end

  // Retired-instruction count; wraps naturally at 2^CNT_W.
  always_comb begin
    if (retire_s) begin
      instret_d = instret_q + CNT_W'(1'b1);
    end else begin
      instret_d = instret_q;
    end
  end

  // Wait counter and retired-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= {WAIT_W{1'b0}};
      instret_q <= {CNT_W{1'b0}};
    end else begin
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Moore output decode from state and opcode; mem_ready and
  // branch_taken only gate the PC/IR load strobes.
  always_comb begin
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    ir_write     = 1'b0;
    imm_sel      = IMM_I;
    alu_src_a    = ALU_A_RS1;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALU_OP_ADD;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_iord     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    illegal_inst = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_iord = 1'b0;
        ir_write = mem_ready;
        pc_write = mem_ready;
        pc_src   = PC_SRC_PLUS4;
      end
      ST_DECODE: begin
        imm_sel = imm_sel_s;
      end
      ST_EXEC: begin
        // The immediate stays selected for as long as the opcode is
        // stable, so EXEC operands and the LUI write-back see it.
        imm_sel = imm_sel_s;
        case (cls_s)
          CLS_R: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_OP_FUNCT;
          end
          CLS_I_ALU: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ADD;
          end
          CLS_BRANCH: begin
            alu_src_a = ALU_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_BRANCH;
            pc_src    = PC_SRC_ALU;
            pc_write  = branch_taken;
          end
          CLS_JAL: begin
            alu_src_a = ALU_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ADD;
            pc_src    = PC_SRC_ALU;
            pc_write  = 1'b1;
          end
          CLS_JALR: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ADD;
            pc_src    = PC_SRC_JALR;
            pc_write  = 1'b1;
          end
          CLS_AUIPC: begin
            alu_src_a = ALU_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ADD;
          end
          default: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_OP_ADD;
          end
        endcase
      end
      ST_MEM: begin
        imm_sel  = imm_sel_s;
        mem_req  = 1'b1;
        mem_iord = 1'b1;
        mem_we   = (cls_s == CLS_STORE);
      end
      ST_WB: begin
        imm_sel   = imm_sel_s;
        reg_write = 1'b1;
        case (cls_s)
          CLS_LOAD:           wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR:  wb_sel = WB_PC4;
          CLS_LUI:            wb_sel = WB_IMM;
          default:            wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: begin
        illegal_inst = 1'b1;
      end
      default: begin
        illegal_inst = 1'b0;
      end
    endcase
  end

  assign instret   = instret_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: every output is packed into one
// vector and compared against hand-built expectations cycle by cycle.
module tb_rv_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        branch_taken;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic [2:0]  imm_sel;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        mem_req;
  logic        mem_we;
  logic        mem_iord;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        illegal_inst;
  logic [31:0] instret;
  logic [2:0]  state_dbg;

  logic [21:0] obs_v;
  int          n_cmp;
  int          n_bad;

  rv_multicycle_ctrl #(.CNT_W(32), .MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .imm_sel      (imm_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_iord     (mem_iord),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .illegal_inst (illegal_inst),
    .instret      (instret),
    .state_dbg    (state_dbg)
  );

  assign obs_v = {pc_write, pc_src, ir_write, imm_sel, alu_src_a, alu_src_b, alu_op,
                  mem_req, mem_we, mem_iord, reg_write, wb_sel, illegal_inst, state_dbg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector in the same field order as obs_v.
  function automatic logic [21:0] ev(input logic pw, input logic [1:0] ps, input logic irw,
                                     input logic [2:0] imm, input logic a, input logic [1:0] b,
                                     input logic [1:0] op, input logic req, input logic we,
                                     input logic iord, input logic rw, input logic [1:0] wb,
                                     input logic ill, input logic [2:0] st);
    return {pw, ps, irw, imm, a, b, op, req, we, iord, rw, wb, ill, st};
  endfunction

  function automatic logic [21:0] f_idle();
    return ev(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
  endfunction
  function automatic logic [21:0] f_trap();
    return ev(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd6);
  endfunction
  function automatic logic [21:0] f_fetch(input logic rdy);
    return ev(rdy, 2'd0, rdy, 3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1);
  endfunction
  function automatic logic [21:0] f_dec(input logic [2:0] imm);
    return ev(1'b0, 2'd0, 1'b0, imm, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd2);
  endfunction
  function automatic logic [21:0] f_exec(input logic pw, input logic [1:0] ps, input logic [2:0] imm,
                                         input logic a, input logic [1:0] b, input logic [1:0] op);
    return ev(pw, ps, 1'b0, imm, a, b, op, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3);
  endfunction
  function automatic logic [21:0] f_mem(input logic [2:0] imm, input logic we);
    return ev(1'b0, 2'd0, 1'b0, imm, 1'b0, 2'd0, 2'd0, 1'b1, we, 1'b1, 1'b0, 2'd0, 1'b0, 3'd4);
  endfunction
  function automatic logic [21:0] f_wb(input logic [2:0] imm, input logic [1:0] wb);
    return ev(1'b0, 2'd0, 1'b0, imm, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, wb, 1'b0, 3'd5);
  endfunction

  task automatic chk_v(input string tag, input logic [21:0] exp);
    n_cmp++;
    assert (obs_v === exp) else begin
      n_bad++;
      $error("FAIL %s: outputs observed %h expected %h", tag, obs_v, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    n_cmp++;
    assert (instret === exp) else begin
      n_bad++;
      $error("FAIL %s: instret observed %0d expected %0d", tag, instret, exp);
    end
  endtask

  // Advance one clock, drive this cycle's inputs, let outputs settle.
  task automatic cyc(input logic rdy, input logic bt);
    @(posedge clk);
    #1;
    mem_ready    = rdy;
    branch_taken = bt;
    #1;
  endtask

  // One non-memory instruction starting from FETCH with mem_ready high.
  task automatic run_simple(input string tag, input logic [6:0] opc, input logic [2:0] imm,
                            input logic pw, input logic [1:0] ps, input logic a,
                            input logic [1:0] b, input logic [1:0] op, input logic [1:0] wb,
                            input logic [31:0] cnt);
    opcode = opc;
    cyc(1'b1, 1'b0); chk_v({tag, "_dec"}, f_dec(imm));
    cyc(1'b1, 1'b0); chk_v({tag, "_exec"}, f_exec(pw, ps, imm, a, b, op));
    cyc(1'b1, 1'b0); chk_v({tag, "_wb"}, f_wb(imm, wb));
    cyc(1'b1, 1'b0); chk_v({tag, "_fetch"}, f_fetch(1'b1));
    chk_cnt({tag, "_instret"}, cnt);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    opcode       = 7'h00;
    #2;
    chk_v("reset_outs", f_idle());
    chk_cnt("reset_instret", 32'd0);

    // ADD x3,x1,x2 (0x002081B3): IDLE FETCH DECODE EXEC WB
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 7'h33;
    #1;
    chk_v("add_c1_idle", f_idle());
    cyc(1'b1, 1'b0); chk_v("add_c2_fetch", f_fetch(1'b1));
    cyc(1'b1, 1'b0); chk_v("add_c3_dec", f_dec(3'd0));
    cyc(1'b1, 1'b0); chk_v("add_c4_exec", f_exec(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd2));
    cyc(1'b1, 1'b0); chk_v("add_c5_wb", f_wb(3'd0, 2'd0));
    cyc(1'b1, 1'b0); chk_v("add_fetch", f_fetch(1'b1));
    chk_cnt("add_instret", 32'd1);

    // LW with three stalled MEM cycles: 8 cycles in total
    opcode = 7'h03;
    cyc(1'b1, 1'b0); chk_v("lw_dec", f_dec(3'd0));
    cyc(1'b1, 1'b0); chk_v("lw_exec", f_exec(1'b0, 2'd0, 3'd0, 1'b0, 2'd1, 2'd0));
    cyc(1'b0, 1'b0); chk_v("lw_mem_w1", f_mem(3'd0, 1'b0));
    cyc(1'b0, 1'b0); chk_v("lw_mem_w2", f_mem(3'd0, 1'b0));
    cyc(1'b0, 1'b0); chk_v("lw_mem_w3", f_mem(3'd0, 1'b0));
    cyc(1'b1, 1'b0); chk_v("lw_mem_done", f_mem(3'd0, 1'b0));
    cyc(1'b1, 1'b0); chk_v("lw_wb", f_wb(3'd0, 2'd1));
    cyc(1'b1, 1'b0); chk_v("lw_fetch", f_fetch(1'b1));
    chk_cnt("lw_instret", 32'd2);

    // BEQ taken then not taken, each retiring in 3 cycles
    opcode = 7'h63;
    cyc(1'b1, 1'b1); chk_v("beq_t_dec", f_dec(3'd2));
    cyc(1'b1, 1'b1); chk_v("beq_t_exec", f_exec(1'b1, 2'd1, 3'd2, 1'b1, 2'd1, 2'd1));
    cyc(1'b1, 1'b1); chk_v("beq_t_fetch", f_fetch(1'b1));
    chk_cnt("beq_t_instret", 32'd3);
    cyc(1'b1, 1'b0); chk_v("beq_n_dec", f_dec(3'd2));
    cyc(1'b1, 1'b0); chk_v("beq_n_exec", f_exec(1'b0, 2'd1, 3'd2, 1'b1, 2'd1, 2'd1));
    cyc(1'b1, 1'b0); chk_v("beq_n_fetch", f_fetch(1'b1));
    chk_cnt("beq_n_instret", 32'd4);

    // Remaining non-memory classes
    run_simple("addi",  7'h13, 3'd0, 1'b0, 2'd0, 1'b0, 2'd1, 2'd2, 2'd0, 32'd5);
    run_simple("jal",   7'h6F, 3'd4, 1'b1, 2'd1, 1'b1, 2'd1, 2'd0, 2'd2, 32'd6);
    run_simple("jalr",  7'h67, 3'd0, 1'b1, 2'd2, 1'b0, 2'd1, 2'd0, 2'd2, 32'd7);
    run_simple("lui",   7'h37, 3'd3, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd3, 32'd8);
    run_simple("auipc", 7'h17, 3'd3, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 32'd9);

    // Illegal opcode traps from DECODE and stays there
    opcode = 7'h7F;
    cyc(1'b1, 1'b0); chk_v("ill_dec", f_dec(3'd0));
    cyc(1'b1, 1'b0); chk_v("ill_trap", f_trap());
    cyc(1'b1, 1'b1); chk_v("ill_trap_sticky", f_trap());
    chk_cnt("ill_instret", 32'd9);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_v("ill_rst_outs", f_idle());
    chk_cnt("ill_rst_instret", 32'd0);

    // Fetch timeout: four stalled FETCH cycles then TRAP
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0; opcode = 7'h33;
    #1;
    chk_v("to_idle", f_idle());
    cyc(1'b0, 1'b0); chk_v("to_w1", f_fetch(1'b0));
    cyc(1'b0, 1'b0); chk_v("to_w2", f_fetch(1'b0));
    cyc(1'b0, 1'b0); chk_v("to_w3", f_fetch(1'b0));
    cyc(1'b0, 1'b0); chk_v("to_w4", f_fetch(1'b0));
    cyc(1'b0, 1'b0); chk_v("to_trap", f_trap());
    cyc(1'b1, 1'b0); chk_v("to_trap_hold", f_trap());
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_v("to_rst_outs", f_idle());

    // Store retires in 4 cycles, then a second store is reset mid-MEM
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 7'h23;
    #1;
    chk_v("sw_idle", f_idle());
    cyc(1'b1, 1'b0); chk_v("sw_fetch", f_fetch(1'b1));
    cyc(1'b1, 1'b0); chk_v("sw_dec", f_dec(3'd1));
    cyc(1'b1, 1'b0); chk_v("sw_exec", f_exec(1'b0, 2'd0, 3'd1, 1'b0, 2'd1, 2'd0));
    cyc(1'b1, 1'b0); chk_v("sw_mem", f_mem(3'd1, 1'b1));
    cyc(1'b1, 1'b0); chk_v("sw_fetch2", f_fetch(1'b1));
    chk_cnt("sw_instret", 32'd1);
    cyc(1'b1, 1'b0); chk_v("sw2_dec", f_dec(3'd1));
    cyc(1'b1, 1'b0); chk_v("sw2_exec", f_exec(1'b0, 2'd0, 3'd1, 1'b0, 2'd1, 2'd0));
    cyc(1'b0, 1'b0); chk_v("sw2_mem_wait", f_mem(3'd1, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_v("sw2_rst_drop", f_idle());
    chk_cnt("sw2_rst_instret", 32'd0);

    // Clean restart after the mid-request reset
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 7'h33;
    #1;
    chk_v("rs_idle", f_idle());
    cyc(1'b1, 1'b0); chk_v("rs_fetch", f_fetch(1'b1));
    run_simple("rs_add", 7'h33, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 2'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and write-back, and drives every datapath select: PC/IR enables, immediate-format select to the immediate generator, ALU operand and op selects, memory request and write-back source. Memory is reached over a req/ready handshake with variable latency. A retired-instruction counter is kept alongside the FSM.

Parameters:
CNT_W, 32, width of retired-instruction counter
MAX_WAIT, 255, memory wait cycles before trap; 0 disables the timeout

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0], stable from DECODE until next ir_write
mem_ready  in  1  memory completes current request this cycle
branch_taken  in  1  comparator result, valid in EXEC
pc_write  out  1  load PC
pc_src  out  2  0=PC+4, 1=ALU result (branch/JAL target), 2=ALU result & ~1 (JALR)
ir_write  out  1  load IR and old_pc
imm_sel  out  3  0=I, 1=S, 2=B, 3=U, 4=J
alu_src_a  out  1  0=rs1, 1=old_pc
alu_src_b  out  2  0=rs2, 1=imm, 2=const 4
alu_op  out  2  0=add, 1=branch compare, 2=funct-decoded
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  store, valid with mem_req
mem_iord  out  1  0=instruction address (PC), 1=data address (ALU out)
reg_write  out  1  register-file write enable
wb_sel  out  2  0=ALU out, 1=mem data, 2=old_pc+4, 3=imm
illegal_inst  out  1  sticky: bad opcode or memory timeout
instret  out  CNT_W  retired-instruction count
state_dbg  out  3  current state encoding

Behaviour:
- The FSM has these states: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- rst_n low (asynchronous): state=IDLE, instret=0, wait counter=0. All outputs are 0 and illegal_inst=0.
- IDLE -> FETCH unconditionally, one cycle after reset release. No outputs are asserted in IDLE.
- FETCH: mem_req=1, mem_iord=0, mem_we=0.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready=1, in the same cycle: ir_write=1, pc_write=1, pc_src=0. Go to DECODE.
- DECODE: imm_sel is set from the opcode. No writes.
  - Legal opcodes go to EXEC.
  - Any other opcode goes to TRAP.
- imm_sel per opcode:
  - 0010011, 0000011 and 1100111 use I.
  - 0100011 uses S.
  - 1100011 uses B.
  - 0110111 and 0010111 use U.
  - 1101111 uses J.
  - 0110011 uses I (don't-care).
- EXEC, per opcode:
  - R (0110011): a=rs1, b=rs2, op=2. Go to WB.
  - I-ALU: a=rs1, b=imm, op=2. Go to WB.
  - LOAD/STORE: a=rs1, b=imm, op=0. Go to MEM.
  - BRANCH: a=old_pc, b=imm, op=1, pc_src=1, pc_write=branch_taken. Go to FETCH (retire).
  - JAL: a=old_pc, b=imm, op=0, pc_src=1, pc_write=1. Go to WB.
  - JALR: a=rs1, b=imm, op=0, pc_src=2, pc_write=1. Go to WB.
  - LUI: no ALU use. Go to WB.
  - AUIPC: a=old_pc, b=imm, op=0. Go to WB.
- MEM: mem_req=1, mem_iord=1, mem_we=1 for STORE. Hold while mem_ready=0.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE goes to FETCH (retire).
- WB: reg_write=1, then go to FETCH (retire). wb_sel per type:
  - R, I-ALU and AUIPC use 0.
  - LOAD uses 1.
  - JAL and JALR use 2.
  - LUI uses 3.
- Retire means instret increments by 1 on that transition and wraps at 2^CNT_W.
- Latency with mem_ready tied high:
  - BRANCH: 3 cycles.
  - STORE, R, I-ALU, JAL, JALR, LUI, AUIPC: 4 cycles.
  - LOAD: 5 cycles.
- Wait timeout: the counter clears on entry to FETCH or MEM and increments each cycle with mem_req=1 and mem_ready=0. When it reaches MAX_WAIT (if non-zero), go to TRAP.
- TRAP: illegal_inst=1, all enables 0. Only rst_n leaves TRAP. instret is frozen.
- mem_req never drops while mem_ready=0 inside FETCH/MEM, and never asserts outside FETCH/MEM.
- Reset asserted mid-request drops mem_req asynchronously.
- Outputs are decoded (Moore) from state and opcode. mem_ready and branch_taken gate only ir_write and pc_write.

Decomposition:
- Package rv_ctrl_pkg holds: state encodings, opcode constants, imm_sel/pc_src/alu_src_b/wb_sel encodings, and alu_op codes. The immediate generator and ALU decoder reuse these.
- One sub-module, rv_ctrl_decode: a combinational opcode -> {legal, imm_sel, class} decoder, shared by DECODE/EXEC/WB.

Test Plan:
- Reset then ADD (0x002081B3), mem_ready high -> IDLE, FETCH, DECODE, EXEC, WB. reg_write=1 with wb_sel=0 only in cycle 5 after release. instret=1.
- LW (opcode 0000011), mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_iord=1, mem_we=0. WB has wb_sel=1. Total 8 cycles.
- BEQ with branch_taken=1, then with branch_taken=0 -> EXEC pc_write=1/pc_src=1, then pc_write=0. imm_sel=2. Both retire in 3 cycles.
- Opcode 0x7F after fetch -> TRAP from DECODE, illegal_inst=1 sticky, instret unchanged. rst_n pulse returns to IDLE with illegal_inst=0.
- MAX_WAIT=4, mem_ready held low in FETCH -> TRAP after exactly 4 wait cycles, mem_req=0 thereafter.
- rst_n asserted mid-MEM for a STORE -> mem_req/mem_we drop the same instant and instret=0. Restart fetches cleanly.
